// File: rtl/pwm_pkg.sv
// Shared constants for the PWM capture path: FSM encoding and default tick timing.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam int unsigned CLK_HZ       = 50_000_000;
  localparam int unsigned TICKS_PER_MS = 50_000;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus an edge flop; reports the synchronized level and
// single-cycle rise/fall pulses, all delayed identically from the pin.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an incoming PWM line in clk ticks, with a
// per-period valid strobe, a pulse-width range flag and a loss-of-signal flag.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned TIMEOUT = 40 * TICKS_PER_MS,
  parameter int unsigned MIN_W   = TICKS_PER_MS,
  parameter int unsigned MAX_W   = 2 * TICKS_PER_MS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  input  logic             enable,
  output logic [CNT_W-1:0] width,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             in_range,
  output logic             no_signal
);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [CNT_W-1:0] hi_cnt, hi_cnt_nxt;
  logic [CNT_W-1:0] width_nxt, period_nxt;
  logic             valid_nxt, in_range_nxt, no_signal_nxt;
  logic             pin_level, rise, fall;
  logic             to_hit, hi_ok;

  sync_edge u_sync (
    .clk   (clk),
    .rst_n (reset),
    .din   (pwm_in),
    .level (pin_level),
    .rise  (rise),
    .fall  (fall)
  );

  // Saturating increment and wide compares so narrow counters never wrap or alias.
  assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
  assign to_hit  = (64'(cnt) == 64'(TIMEOUT));
  assign hi_ok   = (64'(hi_cnt) >= 64'(MIN_W)) && (64'(hi_cnt) <= 64'(MAX_W));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state; an edge at the timeout boundary takes priority over the timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (enable && rise) state_nxt = HIGH;
      HIGH: begin
        if (!enable)                   state_nxt = IDLE;
        else if (fall)                 state_nxt = LOW;
        else if (to_hit && pin_level)  state_nxt = IDLE;
      end
      LOW: begin
        if (!enable)     state_nxt = IDLE;
        else if (rise)   state_nxt = HIGH;
        else if (to_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter and output register next-values.
  always_comb begin
    cnt_nxt       = cnt_inc;
    hi_cnt_nxt    = hi_cnt;
    width_nxt     = width;
    period_nxt    = period;
    valid_nxt     = 1'b0;
    in_range_nxt  = in_range;
    no_signal_nxt = no_signal;
    case (state)
      IDLE: cnt_nxt = (enable && rise) ? CNT_W'(1) : '0;
      HIGH: begin
        if (!enable) begin
          cnt_nxt       = '0;
          no_signal_nxt = 1'b1;
        end else if (fall) begin
          hi_cnt_nxt = cnt;
        end else if (to_hit && pin_level) begin
          cnt_nxt       = '0;
          no_signal_nxt = 1'b1;
        end
      end
      LOW: begin
        if (!enable) begin
          cnt_nxt       = '0;
          no_signal_nxt = 1'b1;
        end else if (rise) begin
          width_nxt     = hi_cnt;
          period_nxt    = cnt;
          valid_nxt     = 1'b1;
          in_range_nxt  = hi_ok;
          no_signal_nxt = 1'b0;
          cnt_nxt       = CNT_W'(1);
        end else if (to_hit) begin
          cnt_nxt       = '0;
          no_signal_nxt = 1'b1;
        end
      end
      default: cnt_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      hi_cnt    <= '0;
      width     <= '0;
      period    <= '0;
      valid     <= 1'b0;
      in_range  <= 1'b0;
      no_signal <= 1'b1;
    end else begin
      cnt       <= cnt_nxt;
      hi_cnt    <= hi_cnt_nxt;
      width     <= width_nxt;
      period    <= period_nxt;
      valid     <= valid_nxt;
      in_range  <= in_range_nxt;
      no_signal <= no_signal_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a small-timeout instance for lock, range,
// timeout and enable behaviour, and an 8-bit instance for counter saturation.
module tb_pwm_capture;

  localparam int unsigned W  = 24;
  localparam int unsigned WB = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          pwm_in = 1'b0;
  logic          pwm_b = 1'b0;
  logic          enable = 1'b0;
  logic [W-1:0]  width, period;
  logic          valid, in_range, no_signal;
  logic [WB-1:0] width_b, period_b;
  logic          valid_b, in_range_b, no_signal_b;

  pwm_capture #(.CNT_W(W), .TIMEOUT(1000), .MIN_W(50), .MAX_W(100)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .pwm_in    (pwm_in),
    .enable    (enable),
    .width     (width),
    .period    (period),
    .valid     (valid),
    .in_range  (in_range),
    .no_signal (no_signal)
  );

  pwm_capture #(.CNT_W(WB), .TIMEOUT(300), .MIN_W(50), .MAX_W(100)) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .pwm_in    (pwm_b),
    .enable    (enable),
    .width     (width_b),
    .period    (period_b),
    .valid     (valid_b),
    .in_range  (in_range_b),
    .no_signal (no_signal_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Record the cycle of every valid strobe, sampled just after the edge.
  int vcyc[$];
  int nvb = 0;
  always begin
    @(posedge clk);
    #1;
    if (valid === 1'b1) vcyc.push_back(cyc);
    if (valid_b === 1'b1) nvb++;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int vat(input int i);
    return (i < vcyc.size()) ? vcyc[i] : -1;
  endfunction

  task automatic pin(input logic v, input int n);
    pwm_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pin_b(input logic v, input int n);
    pwm_b = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int r2, r11;

  initial begin
    enable = 1'b1;
    @(posedge clk);
    #1;

    // Reset held with the pins toggling
    for (int i = 0; i < 5; i++) begin
      pwm_in = ~pwm_in;
      pwm_b  = ~pwm_b;
      @(posedge clk);
      #1;
    end
    chk("rst_width", width, 0);
    chk("rst_period", period, 0);
    chk("rst_valid", valid, 0);
    chk("rst_in_range", in_range, 0);
    chk("rst_no_signal", no_signal, 1);
    chk("rst_valid_count", vcyc.size(), 0);
    chk("rst_b_no_signal", no_signal_b, 1);
    pwm_in = 1'b0;
    pwm_b  = 1'b0;
    reset  = 1'b1;
    pin(0, 20);
    chk("idle_no_signal", no_signal, 1);

    // Lock on 75/425; first publish on the second rise
    r2 = 0;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) r2 = cyc;
      pin(1, 75);
      pin(0, 425);
    end
    chk("lock_count", vcyc.size(), 2);
    chk("lock_first_valid", vat(0), r2 + 3);
    chk("lock_spacing", vat(1) - vat(0), 500);
    chk("lock_width", width, 75);
    chk("lock_period", period, 500);
    chk("lock_in_range", in_range, 1);
    chk("lock_no_signal", no_signal, 0);
    chk("lock_valid_low", valid, 0);

    // Too wide, then too narrow
    pin(1, 120);
    pin(0, 380);
    pin(1, 40);
    chk("wide_width", width, 120);
    chk("wide_period", period, 500);
    chk("wide_in_range", in_range, 0);
    chk("wide_count", vcyc.size(), 4);
    pin(0, 460);
    pin(1, 75);
    chk("narrow_width", width, 40);
    chk("narrow_period", period, 500);
    chk("narrow_in_range", in_range, 0);
    pin(0, 425);

    // Hold low: timeout fires exactly when the count reaches 1000 in LOW
    pin(1, 75);
    chk("pre_to_width", width, 75);
    chk("pre_to_in_range", in_range, 1);
    chk("pre_to_count", vcyc.size(), 6);
    pin(0, 927);
    chk("to_not_yet", no_signal, 0);
    pin(0, 1);
    chk("to_fired", no_signal, 1);
    chk("to_width_hold", width, 75);
    chk("to_period_hold", period, 500);
    chk("to_in_range_hold", in_range, 1);
    pin(0, 50);
    chk("to_no_valid", vcyc.size(), 6);

    // Enable dropped mid-HIGH, then relock
    pin(1, 75);
    pin(0, 425);
    pin(1, 30);
    chk("en_relock_count", vcyc.size(), 7);
    chk("en_relock_no_signal", no_signal, 0);
    enable = 1'b0;
    pin(1, 1);
    chk("en_off_no_signal", no_signal, 1);
    chk("en_off_width_hold", width, 75);
    pin(1, 9);
    enable = 1'b1;
    pin(1, 35);
    pin(0, 425);
    pin(1, 75);
    pin(0, 425);
    chk("en_first_rise_no_valid", vcyc.size(), 7);
    chk("en_still_no_signal", no_signal, 1);
    r11 = cyc;
    pin(1, 20);
    pwm_in = 1'b0;
    chk("en_second_rise_count", vcyc.size(), 8);
    chk("en_second_rise_time", vat(7), r11 + 3);
    chk("en_width", width, 75);
    chk("en_period", period, 500);
    chk("en_no_signal", no_signal, 0);

    // 8-bit counter saturates instead of wrapping
    pin_b(1, 280);
    pin_b(0, 10);
    pin_b(1, 20);
    chk("sat_width", width_b, 255);
    chk("sat_period", period_b, 255);
    chk("sat_in_range", in_range_b, 0);
    chk("sat_valid_count", nvb, 1);
    chk("sat_no_signal", no_signal_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the servo PWM generator: measures high time and period of an incoming PWM signal, e.g. a servo command line or a loopback of our own PWM output.
- Reports both values in clk ticks with a one-cycle valid strobe per completed period.
- Flags loss of signal and out-of-range pulse widths.
- Sits between a board pin and the servo control/self-test logic of the cube robot.

Parameters:
- CNT_W, 24, width of the width/period counters and outputs.
- TIMEOUT, 2_000_000, ticks without a required edge before declaring loss of signal (40 ms at 50 MHz).
- MIN_W, 50_000, smallest in-range high time in ticks (1 ms at 50 MHz).
- MAX_W, 100_000, largest in-range high time in ticks (2 ms at 50 MHz).

Ports:
- clk, input, 1, system clock; all logic on its rising edge.
- reset, input, 1, asynchronous, active-low reset.
- pwm_in, input, 1, asynchronous PWM input from pin.
- enable, input, 1, capture enable; 0 forces IDLE.
- width, output, CNT_W, high time of the last complete period, in ticks.
- period, output, CNT_W, rising-to-rising time of the last complete period, in ticks.
- valid, output, 1, one-cycle strobe when width/period update.
- in_range, output, 1, registered result of MIN_W <= width <= MAX_W for the current width.
- no_signal, output, 1, level; high while timed out or never locked.

Behaviour:
- Reset (reset=0, asynchronous):
  - width=0, period=0, valid=0, in_range=0, no_signal=1.
  - State IDLE, counters 0, synchronizer flops 0.
- Input path:
  - pwm_in passes through a 2-flop synchronizer, then a third flop for edge detect.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - Edges are seen 3 cycles after the pin changes. Both edges carry the same delay, so measured counts are exact.
- Single counter cnt (CNT_W bits), cleared to 1 on a rise and incremented every cycle otherwise.
- Saturation: cnt stops at all-ones and never wraps.
- States:
  - IDLE: cnt held 0. When enable=1 and rise -> HIGH with cnt=1. Any partial pulse before the first rise is discarded.
  - HIGH: on fall, latch hi_cnt=cnt, then -> LOW. A rise cannot occur in HIGH.
  - LOW: on rise, publish and go to HIGH with cnt=1 in the same cycle.
    - Publish means width<=hi_cnt, period<=cnt, valid<=1, no_signal<=0.
    - in_range is updated in the same cycle from hi_cnt.
- Timeout:
  - In HIGH or LOW, when cnt reaches TIMEOUT -> IDLE, no_signal<=1.
  - width, period and in_range keep their last values. No valid pulse.
- valid is high exactly one cycle per publish and low otherwise.
- First publish occurs on the second rise after leaving IDLE.
- enable falling:
  - Next cycle state=IDLE and cnt=0.
  - Outputs hold; no_signal<=1.
  - A publish coinciding with enable=0 is suppressed.
- Constant-high input with no falls times out in HIGH. Constant-low input times out in LOW or stays in IDLE.
- Simultaneous timeout and rise in LOW: the rise wins (publish), because a valid edge is at the boundary.
- Timeout must be >= 1 tick beyond the longest legal period. This is a user responsibility; it is not checked.
- Pulses shorter than 1 tick after synchronization may be missed. There is no glitch filter in this block.

Decomposition:
- Package pwm_pkg holds:
  - the state encoding constants (IDLE=2'd0, HIGH=2'd1, LOW=2'd2);
  - the default timing constants (CLK_HZ=50_000_000, TICKS_PER_MS=50_000).
- One sub-module, sync_edge: 2-flop synchronizer plus edge flop. Outputs level, rise, fall; asynchronous active-low reset. It is reused by future limit-switch and encoder inputs.

Test Plan:
- Sim parameters are TIMEOUT=1000, MIN_W=50, MAX_W=100 unless a line says otherwise.
- 1: Reset held 5 cycles with pwm_in toggling -> all outputs at reset values and no valid.
- 2: After release, drive high 75 / low 425 for 3 periods -> first valid 3 cycles after the 2nd rising pin edge, then one per period; width=75, period=500, in_range=1, no_signal=0.
- 3: High 120 / low 380 -> width=120, period=500, in_range=0. Then high 40 / low 460 -> width=40, in_range=0.
- 4: Hold pwm_in low after a valid period -> no_signal=1 exactly when cnt reaches 1000 in LOW; width/period hold 75/500; no further valid.
- 5: Deassert enable mid-HIGH, reassert 10 cycles later, then resume 75/425 -> no valid for the interrupted period; first new valid on the 2nd rise after re-enable.
- 6: With CNT_W=8 and TIMEOUT=300, drive high 280 / low 10 -> width saturates at 255, in_range=0, no wrap to a small value.
